fix_hb_tx_scheduler: RTL and testbench

//  Transmit-side FIX heartbeat scheduler, the outbound counterpart of the inbound heartbeat timeout counter.
//  - Times the outbound idle interval.
//  - Requests a Heartbeat (35=0) from the message builder when no outbound message has been sent for
//    hb_interval_i units.
//  - Answers an inbound TestRequest (35=1) with a Heartbeat that echoes TestReqID (112).

---
 rtl/fix_hb_tx_scheduler.sv | 136 +++++++++++++
 tb/tb_fix_hb_tx_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fix_hb_tx_scheduler.sv
// Outbound FIX heartbeat scheduler: times the outbound idle interval and requests Heartbeats,
// including TestRequest answers that echo the TestReqID.
module fix_hb_tx_scheduler #(
  parameter int unsigned HB_RANGE = 16,
  parameter int unsigned ID_W     = 32,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_i,
  input  logic [HB_RANGE-1:0] hb_interval_i,
  input  logic                tx_msg_sent_i,
  input  logic                test_req_i,
  input  logic [ID_W-1:0]     test_req_id_i,
  output logic                hb_req_valid_o,
  input  logic                hb_req_ready_i,
  output logic                hb_has_id_o,
  output logic [ID_W-1:0]     hb_id_o,
  output logic                test_req_dropped_o
);

  localparam int unsigned PsW = $clog2(PRESCALE + 1);
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StCount, StReq} state_e;

  state_e              state_q, state_d;
  logic [HB_RANGE-1:0] cnt_q, cnt_d;
  logic [PsW-1:0]      ps_q, ps_d;
  logic                pend_valid_q, pend_valid_d;
  logic [ID_W-1:0]     pend_id_q, pend_id_d;
  logic                has_id_q, has_id_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                dropped_q, dropped_d;

  logic                strobe, due, handshake, slot_free, go_req;
  logic [HB_RANGE:0]   cnt_inc;

  assign strobe    = (ps_q == PsLast);
  assign cnt_inc   = {1'b0, cnt_q} + (HB_RANGE + 1)'(1);
  assign due       = strobe && (hb_interval_i != '0) && (cnt_inc >= {1'b0, hb_interval_i});
  assign handshake = (state_q == StReq) && hb_req_ready_i;
  // The pending id is the one the current request carries; a handshake frees the slot.
  assign slot_free = !pend_valid_q || (handshake && has_id_q);
  assign go_req    = !tx_msg_sent_i && (due || pend_valid_q || test_req_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (enable_i) state_d = StCount;
      StCount: if (go_req) state_d = StReq;
      StReq:   if (hb_req_ready_i) state_d = StCount;
      default: state_d = StIdle;
    endcase
    if (!enable_i) state_d = StIdle;
  end

  always_comb begin
    cnt_d        = cnt_q;
    ps_d         = ps_q;
    pend_valid_d = pend_valid_q;
    pend_id_d    = pend_id_q;
    has_id_d     = has_id_q;
    id_d         = id_q;
    dropped_d    = 1'b0;
    if (!enable_i || state_q == StIdle) begin
      cnt_d        = '0;
      ps_d         = '0;
      pend_valid_d = 1'b0;
      pend_id_d    = '0;
      has_id_d     = 1'b0;
      id_d         = '0;
    end else begin
      if (handshake && has_id_q) pend_valid_d = 1'b0;
      if (test_req_i) begin
        if (slot_free) begin
          pend_valid_d = 1'b1;
          pend_id_d    = test_req_id_i;
        end else begin
          dropped_d = 1'b1;
        end
      end
      if (state_q == StCount) begin
        if (tx_msg_sent_i) begin
          cnt_d = '0;
          ps_d  = '0;
        end else if (go_req) begin
          has_id_d = pend_valid_q || test_req_i;
          id_d     = pend_valid_q ? pend_id_q : (test_req_i ? test_req_id_i : '0);
        end else begin
          ps_d = strobe ? '0 : ps_q + PsW'(1);
          if (strobe && cnt_q != '1) cnt_d = cnt_q + HB_RANGE'(1);
        end
      end else if (handshake) begin
        cnt_d = '0;
        ps_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      ps_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_id_q    <= '0;
      has_id_q     <= 1'b0;
      id_q         <= '0;
      dropped_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      ps_q         <= ps_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
      has_id_q     <= has_id_d;
      id_q         <= id_d;
      dropped_q    <= dropped_d;
    end
  end

  always_comb begin
    hb_req_valid_o     = (state_q == StReq);
    hb_has_id_o        = hb_req_valid_o && has_id_q;
    hb_id_o            = hb_has_id_o ? id_q : '0;
    test_req_dropped_o = dropped_q;
  end

endmodule

// File: tb/tb_fix_hb_tx_scheduler.sv
// Scoreboard bench for fix_hb_tx_scheduler: a behavioural model predicts every cycle's outputs and
// each handshake payload; a negedge monitor compares. A second instance covers PRESCALE=4.
module tb_fix_hb_tx_scheduler;

  localparam int P = 1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, enable = 1'b0, sent = 1'b0, tr = 1'b0, ready = 1'b1;
  logic [15:0] iv = 16'd5;
  logic [31:0] trid = '0;
  logic        valid, has_id, dropped;
  logic [31:0] id;

  logic        rst4 = 1'b1, en4 = 1'b0;
  logic [15:0] iv4 = 16'd3;
  logic        valid4, has_id4, dropped4;
  logic [31:0] id4;
  logic        done4 = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fix_hb_tx_scheduler #(.HB_RANGE(16), .ID_W(32), .PRESCALE(1)) u_dut (
    .clk(clk), .rst(rst), .enable_i(enable), .hb_interval_i(iv), .tx_msg_sent_i(sent),
    .test_req_i(tr), .test_req_id_i(trid), .hb_req_valid_o(valid), .hb_req_ready_i(ready),
    .hb_has_id_o(has_id), .hb_id_o(id), .test_req_dropped_o(dropped)
  );

  fix_hb_tx_scheduler #(.HB_RANGE(16), .ID_W(32), .PRESCALE(4)) u_dut4 (
    .clk(clk), .rst(rst4), .enable_i(en4), .hb_interval_i(iv4), .tx_msg_sent_i(1'b0),
    .test_req_i(1'b0), .test_req_id_i(32'h0), .hb_req_valid_o(valid4), .hb_req_ready_i(1'b1),
    .hb_has_id_o(has_id4), .hb_id_o(id4), .test_req_dropped_o(dropped4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: mode 0 = logged off, 1 = timing idle, 2 = requesting.
  int          m_mode = 0;
  int          m_elapsed = 0;
  logic [31:0] m_pend[$];
  bit          m_pl_has = 0;
  logic [31:0] m_pl_id = '0;
  bit          m_drop_next = 0;
  bit [1:0]    exp_v_q[$];
  bit [32:0]   exp_hs_q[$];

  task automatic model_step();
    bit had_pend;
    bit due;
    exp_v_q.push_back({m_mode == 2, m_drop_next});
    if (m_mode == 2 && ready) exp_hs_q.push_back({m_pl_has, m_pl_has ? m_pl_id : 32'h0});
    m_drop_next = 0;
    if (rst || !enable) begin
      m_mode = 0;
      m_pend.delete();
      m_elapsed = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
      m_elapsed = 0;
    end else if (m_mode == 1) begin
      had_pend = m_pend.size() != 0;
      if (tr) begin
        if (!had_pend) m_pend.push_back(trid);
        else m_drop_next = 1;
      end
      // A unit boundary is reached every P clocks of idle time.
      due = (iv != 0) && ((m_elapsed + 1) % P == 0) && ((m_elapsed + 1) / P >= int'(iv));
      if (sent) m_elapsed = 0;
      else if (due || had_pend || tr) begin
        m_mode   = 2;
        m_pl_has = had_pend || tr;
        m_pl_id  = had_pend ? m_pend[0] : trid;
      end else m_elapsed++;
    end else begin
      if (ready) begin
        if (m_pl_has) void'(m_pend.pop_front());
        m_mode = 1;
        m_elapsed = 0;
      end
      if (tr) begin
        if (m_pend.size() == 0) m_pend.push_back(trid);
        else m_drop_next = 1;
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    model_step();
  end

  always @(negedge clk) begin
    bit [1:0]  ev;
    bit [32:0] eh;
    if (exp_v_q.size() != 0) begin
      ev = exp_v_q.pop_front();
      check("valid", 64'(valid), 64'(ev[1]));
      check("dropped", 64'(dropped), 64'(ev[0]));
      if (!valid) check("idle_payload", {31'h0, has_id, id}, 64'h0);
      if (valid && ready) begin
        if (exp_hs_q.size() == 0) begin
          check("unexpected_handshake", 64'(1), 64'(0));
        end else begin
          eh = exp_hs_q.pop_front();
          check("has_id", 64'(has_id), 64'(eh[32]));
          check("id", 64'(id), 64'(eh[31:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    sent = 1'b0;
    tr   = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!valid && n < budget) begin
      tick();
      n++;
    end
    if (!valid) check("wait_valid_timeout", 64'(0), 64'(1));
  endtask

  // PRESCALE=4 instance: interval 3 -> request 12 cycles after COUNT entry; interval 0 -> none.
  initial begin
    int n;
    int seen;
    repeat (3) @(posedge clk);
    #1;
    rst4 = 1'b0;
    en4  = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!valid4 && n < 40);
    check("p4_first_latency", 64'(n), 64'(13));
    check("p4_has_id", 64'(has_id4), 64'(0));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!valid4 && n < 40);
    check("p4_period", 64'(n), 64'(13));
    iv4 = 16'd0;
    repeat (2) @(posedge clk);
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (valid4) seen++;
    end
    check("p4_interval0_quiet", 64'(seen), 64'(0));
    done4 = 1'b1;
  end

  initial begin
    repeat (3) tick();
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_has_id", 64'(has_id), 64'(0));
    check("rst_id", 64'(id), 64'(0));
    check("rst_dropped", 64'(dropped), 64'(0));
    rst = 1'b0;

    // Free-running timed heartbeats.
    enable = 1'b1;
    repeat (30) tick();

    // Sends restart the idle timer; one lands on a due cycle.
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 3 || i == 7) sent = 1'b1;
    end
    wait_valid(20);
    repeat (4) tick();
    sent = 1'b1;
    repeat (8) tick();

    // TestRequest answered next cycle with the echoed id.
    tr = 1'b1;
    trid = 32'h0000_A5A5;
    repeat (10) tick();

    // Stalled builder: first id held pending, second dropped.
    ready = 1'b0;
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) begin tr = 1'b1; trid = 32'h11; end
      if (i == 5) begin tr = 1'b1; trid = 32'h22; end
    end
    ready = 1'b1;
    repeat (10) tick();

    // Logoff during a stalled request, then a fresh timeout.
    ready = 1'b0;
    wait_valid(20);
    tick();
    enable = 1'b0;
    tick();
    enable = 1'b1;
    ready = 1'b1;
    repeat (15) tick();

    // Randomised traffic, including live interval changes and occasional logoffs.
    for (int i = 0; i < 4000; i++) begin
      tick();
      ready  = ($urandom_range(0, 9) < 7);
      enable = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 11) == 0) sent = 1'b1;
      if ($urandom_range(0, 14) == 0) begin
        tr = 1'b1;
        trid = $urandom;
      end
      if ($urandom_range(0, 99) == 0) iv = 16'($urandom_range(0, 8));
    end

    enable = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 2000 && !done4; i++) tick();
    check("p4_done", 64'(done4), 64'(1));
    check("hs_leftover", 64'(exp_hs_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
